muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 36 +++
 rtl/muldiv_ctrl.sv | 133 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/muldiv_ctrl_pkg.sv
// Shared MIPS encodings: ALU control, multiply/divide ops and the
// iterative multiply/divide FSM states.
package muldiv_ctrl_pkg;

    // Iterations of the shift-add / restoring-subtract loop (one per bit).
    localparam int MD_ITERS = 32;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    // Bit 1 selects divide, bit 0 selects unsigned.
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring divide.
// {hi,lo} is the working pair: product/multiplier or remainder/quotient.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH+1:0] diff;

    // Add multiplicand when multiplier LSB set, or trial-subtract divisor and restore on borrow.
    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, b} : '0);
        rem_sh  = {hi, lo[WIDTH-1]};
        diff    = {1'b0, rem_sh} - {2'b00, b};
        hi_next = sum[WIDTH:1];
        lo_next = {sum[0], lo[WIDTH-1:1]};
        if (is_div) begin
            if (!diff[WIDTH+1]) begin
                hi_next = diff[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = rem_sh[WIDTH-1:0];
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Fixed latency: WIDTH RUN cycles plus one FIX cycle for sign correction.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = MD_ITERS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             MtHiE,
    input  logic             MtLoE,
    input  logic             HiLoUseD,
    output logic             BusyE,
    output logic             StallD,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    md_state_e state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi, lo, wh, wl, b_reg, a_raw;
    logic             is_div, sign_a, sign_b, div0;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div),
        .hi      (wh),
        .lo      (wl),
        .b       (b_reg),
        .hi_next (step_hi),
        .lo_next (step_lo)
    );

    // Operand magnitudes at acceptance, and sign correction of the finished result.
    always_comb begin
        a_neg    = ~MdOpE[0] & SrcAE[WIDTH-1];
        b_neg    = ~MdOpE[0] & SrcBE[WIDTH-1];
        a_mag    = a_neg ? -SrcAE : SrcAE;
        b_mag    = b_neg ? -SrcBE : SrcBE;
        prod_fix = (sign_a ^ sign_b) ? -{wh, wl} : {wh, wl};
        quo_fix  = (sign_a ^ sign_b) ? -wl : wl;
        rem_fix  = sign_a ? -wh : wh;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= MD_IDLE;
        else       state <= state_next;
    end

    // Next-state: accept in IDLE, count out WIDTH steps, one fixup cycle.
    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (StartE) state_next = MD_RUN;
            MD_RUN:  if (cnt == LAST) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Datapath: operand latch, iteration, HI/LO writeback and moves.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            wh     <= '0;
            wl     <= '0;
            b_reg  <= '0;
            a_raw  <= '0;
            is_div <= 1'b0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            div0   <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (StartE) begin
                        cnt    <= '0;
                        wh     <= '0;
                        wl     <= a_mag;
                        b_reg  <= b_mag;
                        a_raw  <= SrcAE;
                        is_div <= MdOpE[1];
                        sign_a <= a_neg;
                        sign_b <= b_neg;
                        div0   <= (SrcBE == '0);
                    end else begin
                        if (MtHiE) hi <= SrcAE;
                        if (MtLoE) lo <= SrcAE;
                    end
                end
                MD_RUN: begin
                    wh  <= step_hi;
                    wl  <= step_lo;
                    cnt <= cnt + 1'b1;
                end
                MD_FIX: begin
                    if (!is_div) begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end else if (div0) begin
                        // Divide by zero reports the raw dividend and all-ones quotient.
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BusyE  = (state == MD_RUN) || (state == MD_FIX);
    assign StallD = BusyE & HiLoUseD;
    assign HiE    = hi;
    assign LoE    = lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: vector table plus hand-written corner sequences.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        reset, StartE, MtHiE, MtLoE, HiLoUseD;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE, SrcBE;
    logic        BusyE, StallD;
    logic [31:0] HiE, LoE;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[10];

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .MdOpE    (MdOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .MtHiE    (MtHiE),
        .MtLoE    (MtLoE),
        .HiLoUseD (HiLoUseD),
        .BusyE    (BusyE),
        .StallD   (StallD),
        .HiE      (HiE),
        .LoE      (LoE)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pulse StartE for one edge, then count busy cycles (bounded).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy);
        MdOpE  = op;
        SrcAE  = a;
        SrcBE  = b;
        StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        busy = 0;
        while (BusyE === 1'b1 && busy < 100) begin
            busy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n, bad;
        logic [31:0] hi_before;

        vecs[0] = '{"multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{"div_neg7_2",  2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4] = '{"divu_by0",    2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
        vecs[5] = '{"div_by0_neg", 2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[6] = '{"divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7] = '{"mult_m2xm3",  2'b00, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006};
        vecs[8] = '{"div_7_m2",    2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9] = '{"multu_2p16",  2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};

        reset = 1'b1; StartE = 1'b1; MtHiE = 1'b0; MtLoE = 1'b0; HiLoUseD = 1'b1;
        MdOpE = 2'b01; SrcAE = 32'd7; SrcBE = 32'd9;
        @(negedge clk);
        @(negedge clk);
        StartE = 1'b0;
        reset  = 1'b0;
        // StartE held during reset must not have launched an operation.
        check("reset_busy",  {63'd0, BusyE},  64'd0);
        check("reset_stall", {63'd0, StallD}, 64'd0);
        check("reset_hilo",  {HiE, LoE},      64'd0);
        HiLoUseD = 1'b0;

        // Moves in IDLE.
        SrcAE = 32'h00001234; MtHiE = 1'b1;
        @(negedge clk);
        MtHiE = 1'b0; SrcAE = 32'h0000ABCD; MtLoE = 1'b1;
        @(negedge clk);
        MtLoE = 1'b0;
        check("mt_hilo", {HiE, LoE}, {32'h00001234, 32'h0000ABCD});

        // Vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check({vecs[i].name, "_busy"}, 64'(n), 64'd33);
            check({vecs[i].name, "_hi"},   {32'd0, HiE}, {32'd0, vecs[i].hi});
            check({vecs[i].name, "_lo"},   {32'd0, LoE}, {32'd0, vecs[i].lo});
        end

        // StartE coinciding with moves: start wins, moves dropped.
        MtHiE = 1'b1; MtLoE = 1'b1;
        run_op(2'b01, 32'd3, 32'd4, n);
        MtHiE = 1'b0; MtLoE = 1'b0;
        check("start_wins", {HiE, LoE}, {32'd0, 32'd12});

        // Stall during MULT; mid-run StartE/MtHiE ignored.
        HiLoUseD = 1'b1;
        hi_before = HiE;
        MdOpE = 2'b00; SrcAE = 32'hFFFFFFFD; SrcBE = 32'h00000005; StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        n = 0; bad = 0;
        while (BusyE === 1'b1 && n < 100) begin
            n++;
            if (StallD !== 1'b1) bad++;
            if (n == 8) check("hi_hold_midrun", {32'd0, HiE}, {32'd0, hi_before});
            if (n == 5) begin
                StartE = 1'b1; MtHiE = 1'b1; MdOpE = 2'b01;
                SrcAE = 32'h0000DEAD; SrcBE = 32'd2;
            end else begin
                StartE = 1'b0; MtHiE = 1'b0;
            end
            @(negedge clk);
        end
        check("stall_busy",   64'(n),   64'd33);
        check("stall_cycles", 64'(bad), 64'd0);
        check("stall_result", {HiE, LoE}, {32'hFFFFFFFF, 32'hFFFFFFF1});
        check("stall_idle",   {63'd0, StallD}, 64'd0);
        @(negedge clk);
        check("no_restart", {63'd0, BusyE}, 64'd0);

        // Reset at RUN cycle 10 of DIVU.
        MdOpE = 2'b11; SrcAE = 32'd1000; SrcBE = 32'd3; StartE = 1'b1;
        @(negedge clk);
        StartE = 1'b0;
        n = 0;
        while (BusyE === 1'b1 && n < 10) begin
            n++;
            if (n < 10) @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_busy",  {63'd0, BusyE},  64'd0);
        check("rst_mid_stall", {63'd0, StallD}, 64'd0);
        check("rst_mid_hilo",  {HiE, LoE},      64'd0);
        @(negedge clk);
        check("rst_mid_stays_idle", {63'd0, BusyE}, 64'd0);
        run_op(2'b01, 32'd3, 32'd4, n);
        check("post_rst_busy", 64'(n), 64'd33);
        check("post_rst_mult", {HiE, LoE}, {32'd0, 32'd12});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
